// File: rtl/logic_gate_pipe.sv
// Registered WIDTH-bit bitwise logic unit with eight operations, valid/ready on both
// sides, a 2-entry in-order result buffer, zero/ones flags and an accept counter.
module logic_gate_pipe #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   Y,
    output logic               Y_zero,
    output logic               Y_ones,
    output logic [COUNT_W-1:0] op_count
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
    // in_ready depends only on registered occupancy, never on out_ready.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    typedef struct packed {
        logic             zero;
        logic             ones;
        logic [WIDTH-1:0] y;
    } entry_t;

    buf_state_t         state;
    buf_state_t         state_nxt;
    entry_t             head;
    entry_t             tail;
    entry_t             res;
    logic               accept;
    logic               pop;
    logic               load_head;
    logic               load_tail;
    logic               shift;
    logic [COUNT_W-1:0] count_q;

    always_comb begin
        res.y = '0;
        case (op)
            3'd0:    res.y = A & B;
            3'd1:    res.y = A | B;
            3'd2:    res.y = A ^ B;
            3'd3:    res.y = ~(A & B);
            3'd4:    res.y = ~(A | B);
            3'd5:    res.y = ~(A ^ B);
            3'd6:    res.y = A & ~B;
            default: res.y = A;
        endcase
        res.zero = (res.y == '0);
        res.ones = (res.y == '1);
    end

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_head = 1'b0;
        load_tail = 1'b0;
        shift     = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = ONE;
                    load_head = 1'b1;
                end
            end
            ONE: begin
                case ({accept, pop})
                    2'b10: begin
                        state_nxt = FULL;
                        load_tail = 1'b1;
                    end
                    2'b01:   state_nxt = EMPTY;
                    // Concurrent accept and pop: the new result replaces the head, no bubble.
                    2'b11:   load_head = 1'b1;
                    default: state_nxt = ONE;
                endcase
            end
            FULL: begin
                if (pop) begin
                    state_nxt = ONE;
                    shift     = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (load_head) begin
                head <= res;
            end else if (shift) begin
                head <= tail;
            end
            if (load_tail) begin
                tail <= res;
            end
            if (accept) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    // The head register keeps stale data after the last pop, so outputs are gated.
    assign Y        = out_valid ? head.y : '0;
    assign Y_zero   = out_valid ? head.zero : 1'b0;
    assign Y_ones   = out_valid ? head.ones : 1'b0;
    assign op_count = count_q;

endmodule

// File: doc/logic_gate_pipe.md
# logic_gate_pipe

Parametrised, registered successor to the team's single-bit AND gate: a WIDTH-bit bitwise logic unit with eight selectable operations, a valid/ready handshake on both sides and a 2-entry output buffer. It sits between a stimulus/control source and any downstream consumer that may stall. Every accepted operand pair produces exactly one result, in order, with no loss under backpressure. It also provides zero/all-ones result flags and a transaction counter for bench-side checking.

## Interface
Parameters:
- WIDTH, default 8: operand and result width in bits (≥1).
- COUNT_W, default 16: width of the accepted-transaction counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  operand pair and op are valid this cycle.
- in_ready  output  1  block can accept this cycle.
- op  input  3  operation select, sampled on accept.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- out_valid  output  1  Y and flags hold a valid result.
- out_ready  input  1  consumer takes the result this cycle.
- Y  output  WIDTH  result at buffer head.
- Y_zero  output  1  result at head is all zeros.
- Y_ones  output  1  result at head is all ones.
- op_count  output  COUNT_W  number of accepted transactions, modulo 2^COUNT_W.

## Operation
- Op encoding (all 8 codes defined):
  - 0 AND: A&B
  - 1 OR: A|B
  - 2 XOR: A^B
  - 3 NAND: ~(A&B)
  - 4 NOR: ~(A|B)
  - 5 XNOR: ~(A^B)
  - 6 ANDN: A&~B
  - 7 PASS: A
- Accept occurs when in_valid && in_ready. The result is computed combinationally from A, B and op and written into the buffer together with Y_zero and Y_ones. The flags are stored per entry, not recomputed from Y.
- Pop occurs when out_valid && out_ready.
- Buffer: 2-entry in-order FIFO with occupancy cnt ∈ {0,1,2}.
  - in_ready = (cnt != 2), driven combinationally from registered state only; it has no combinational path from out_ready.
  - out_valid = (cnt != 0).
- Buffer states and transitions, evaluated per edge:
  - EMPTY (cnt=0): accept → ONE.
  - ONE (cnt=1):
    - accept only → FULL
    - pop only → EMPTY
    - accept and pop → ONE, with the new entry becoming the head
  - FULL (cnt=2): in_ready=0, so no accept. Pop → ONE.
- Y, Y_zero and Y_ones always reflect the head entry. When out_valid=0 they are 0 and hold no meaning.
- op_count increments by 1 on every accept and wraps from 2^COUNT_W−1 to 0. It is unaffected by pops.
- While out_valid=1 and out_ready=0, Y and the flags stay stable until a pop occurs.
- With WIDTH=1 the block degenerates to a registered single-bit gate, and Y_zero equals ~Y.

## Timing
- Latency: a transaction accepted at edge k is visible on Y with out_valid=1 from edge k onward (1 cycle), provided it is the head entry.
- Throughput: 1 transaction per cycle whenever out_ready is held at 1. No bubble is inserted on simultaneous accept and pop.
- Under backpressure, at most 2 results are buffered. in_ready drops on the edge where cnt becomes 2 and rises on the edge after the first pop.
- Reset asserted (asynchronous, any time, including mid-transfer):
  - cnt=0, out_valid=0, Y=0, Y_zero=0, Y_ones=0, op_count=0; buffered results are discarded.
  - in_ready reads 1.
  - No accept or pop takes effect while rst=1.
- Reset deassertion is synchronised externally. The first accept can occur on the first rising edge with rst=0.

## Test plan
- Reset then single ops, WIDTH=8, A=8'hF0, B=8'hCC, op 0..7 one per cycle with out_ready=1. Required Y sequence: 8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'h30, 8'hF0, each one cycle after its accept. Final op_count=8.
- Flags: op=0 with A=8'h0F, B=8'hF0 gives Y=8'h00 and Y_zero=1. Then op=5 with A=B=8'hA5 gives Y=8'hFF and Y_ones=1.
- Backpressure, with out_ready=0 and 3 consecutive valid transactions:
  - The first two are accepted and in_ready=0 from the second accept edge.
  - The third is held.
  - Raising out_ready drains them in order, and the third is accepted on the edge after the first pop. op_count=3.
- Simultaneous accept and pop at cnt=1 for 20 cycles with random A/B/op: cnt stays 1, results match the model in order, and none are dropped or duplicated.
- Async reset mid-operation: fill to cnt=2, then pulse rst between clock edges. out_valid, Y and op_count go to 0 immediately without waiting for a clock edge, and in_ready=1.
- Counter wrap: with COUNT_W=4, 17 accepts end with op_count=1.
